// File: rtl/byte_serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin processed one SLICE-bit slice per clock,
// LSB first, with the borrow rippled through a registered flop.
module byte_serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SW     = SLICE + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ready_nxt;
    logic             valid_nxt;
    logic             accept;
    logic             step;
    logic             finish;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    int unsigned      base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SW-1:0]    slice_res;
    logic [WIDTH-1:0] diff_nxt;

    // State and handshake registers; start_ready stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_ready  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_ready  <= ready_nxt;
            result_valid <= valid_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid && start_ready) state_nxt = RUN;
            RUN:     if (cnt == LAST)                state_nxt = DONE;
            DONE:    if (result_ready)               state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // Output / enable decode
    always_comb begin
        ready_nxt = 1'b0;
        valid_nxt = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        ready_nxt = (state_nxt == IDLE);
        valid_nxt = (state_nxt == DONE);
        accept    = (state == IDLE) && start_valid && start_ready;
        step      = (state == RUN);
        finish    = step && (cnt == LAST);
    end

    // One slice of the subtraction, SLICE+1 bits wide so the top bit is the borrow
    always_comb begin
        base      = 32'(cnt) * SLICE;
        a_sl      = op_a[base +: SLICE];
        b_sl      = op_b[base +: SLICE];
        slice_res = {1'b0, a_sl} - {1'b0, b_sl} - SW'(borrow);
        diff_nxt  = diff;
        diff_nxt[base +: SLICE] = slice_res[SLICE-1:0];
    end

    // Datapath registers and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            op_a   <= a;
            op_b   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (step) begin
            diff   <= diff_nxt;
            borrow <= slice_res[SLICE];
            cnt    <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            if (finish) begin
                bout <= slice_res[SLICE];
                zero <= (diff_nxt == '0);
                neg  <= diff_nxt[WIDTH-1];
                ovf  <= (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_nxt[WIDTH-1] != op_a[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Self-checking bench for byte_serial_subtractor against an integer-arithmetic reference.
module tb_byte_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    byte_serial_subtractor #(.WIDTH(32), .SLICE(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .bin          (bin),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .diff         (diff),
        .bout         (bout),
        .zero         (zero),
        .neg          (neg),
        .ovf          (ovf)
    );

    // Reference: {ovf, neg, zero, bout, diff} from plain 64-bit integer arithmetic
    function automatic logic [35:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
        longint ud, sd, max_s, min_s;
        logic [31:0] d;
        logic bo, o;
        max_s = 64'sd2147483647;
        min_s = -max_s - 64'sd1;
        ud = longint'(x) - longint'(y) - longint'(bi);
        sd = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        d  = ud[31:0];
        bo = (ud < 0);
        o  = (sd > max_s) || (sd < min_s);
        return {o, d[31], (d == 32'd0), bo, d};
    endfunction

    // Drives one full transaction; returns observed outputs and latency in cycles
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic bi,
                         output logic [35:0] got, output int lat);
        int guard = 0;
        while (!start_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        a = x; b = y; bin = bi; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        got = {ovf, neg, zero, bout, diff};
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        checks++;
        if ({start_ready, result_valid, diff, bout, zero, neg, ovf} !== 37'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", {start_ready, result_valid, diff, bout, zero, neg, ovf});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", start_ready, result_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [6] = '{32'h5, 32'h0, 32'h80000000, 32'h12345678, 32'hABCD0000, 32'h7FFFFFFF};
        logic [31:0] vb [6] = '{32'h3, 32'h1, 32'h1,        32'h12345677, 32'hABCD0000, 32'hFFFFFFFF};
        logic        vi [6] = '{1'b0,  1'b0,  1'b0,         1'b1,         1'b1,         1'b0};
        logic [35:0] got, exp;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vi[i], got, lat);
            exp = ref_sub(va[i], vb[i], vi[i]);
            checks++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL vec%0d_latency: got %0d expected 4", i, lat);
            end
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL vec%0d_result: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic bi;
        logic [35:0] got, exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x  = $urandom;
            y  = (i % 5 == 0) ? x : $urandom;
            bi = 1'($urandom_range(0, 1));
            do_op(x, y, bi, got, lat);
            exp = ref_sub(x, y, bi);
            checks++;
            if (got !== exp || lat !== 4) begin
                fails++;
                $display("FAIL rand%0d: a=%h b=%h bin=%b got %h lat %0d expected %h lat 4", i, x, y, bi, got, lat, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] got, exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(32'h1000 * i, 32'h1, 1'b0, got, lat);
            exp = ref_sub(32'h1000 * i, 32'h1, 1'b0);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL b2b%0d_result: got %h expected %h", i, got, exp);
            end
            checks++;
            if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b%0d_return_idle: got valid=%b ready=%b expected valid=0 ready=1", i, result_valid, start_ready);
            end
        end
    endtask

    task automatic test_ready_held();
        int lat = 0;
        result_ready = 1'b1;
        a = 32'h00010000; b = 32'h00000001; bin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        while (!result_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 4 || diff !== 32'h0000FFFF || bout !== 1'b0) begin
            fails++;
            $display("FAIL ready_held_result: got lat=%0d diff=%h bout=%b expected lat=4 diff=0000ffff bout=0", lat, diff, bout);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_held_single_cycle: got valid=%b ready=%b expected valid=0 ready=1", result_valid, start_ready);
        end
        result_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        a = 32'h000000FF; b = 32'h00000100; bin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h55555555; b = 32'h11111111; start_valid = 1'b1;
            checks++;
            if (start_ready !== 1'b0 || result_valid !== 1'b0) begin
                fails++;
                $display("FAIL bp_run%0d: got ready=%b valid=%b expected ready=0 valid=0", i, start_ready, result_valid);
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            start_valid = 1'b1;
            checks++;
            if (result_valid !== 1'b1 || start_ready !== 1'b0 || diff !== 32'hFFFFFFFF || bout !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b diff=%h bout=%b expected valid=1 ready=0 diff=ffffffff bout=1",
                         i, result_valid, start_ready, diff, bout);
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0; result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", result_valid, start_ready);
        end
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (result_valid !== 1'b0 || diff !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL bp_no_capture: got valid=%b diff=%h expected valid=0 diff=ffffffff", result_valid, diff);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] got;
        int lat;
        a = 32'h12345678; b = 32'h00000001; bin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, result_valid, diff, bout, zero, neg, ovf} !== 37'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {start_ready, result_valid, diff, bout, zero, neg, ovf});
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release: got ready=%b valid=%b expected ready=1 valid=0", start_ready, result_valid);
        end
        do_op(32'h10, 32'h01, 1'b0, got, lat);
        checks++;
        if (got[31:0] !== 32'h0000000F || lat !== 4) begin
            fails++;
            $display("FAIL reset_mid_fresh_op: got diff=%h lat=%0d expected diff=0000000f lat=4", got[31:0], lat);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_ready_held();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/byte_serial_subtractor.md
Name: byte_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor for the ALU32 datapath: computes a - b - bin one SLICE-bit slice per clock, LSB slice first, rippling the borrow between slices in a registered borrow flop.
- This is the subtract-direction counterpart of the 8-bit ripple-carry adder slice. It is a low-area alternative for the SUB/CMP path.
- Operands enter over a valid/ready handshake. Difference and flags leave over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle.
- NSLICE = WIDTH/SLICE (4 by default). This is a derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_valid  input  1  operands a, b, bin are valid.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- result_valid  output  1  diff and flags are valid.
- result_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff unsigned a < b + bin.
- zero  output  1  diff == 0.
- neg  output  1  diff[WIDTH-1].
- ovf  output  1  signed overflow.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - state = IDLE.
  - start_ready=0 during reset, then 1 from the first cycle after deassertion.
  - result_valid=0.
  - diff, bout, zero, neg, ovf = 0.
  - Internal operand registers, borrow flop and slice counter = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - On a clock edge with start_valid=1: capture a, b and bin (bin goes into the borrow flop), set cnt=0, go to RUN.
  - Operand inputs are sampled only at this acceptance edge; later changes have no effect.
- RUN:
  - start_ready=0.
  - Each edge computes slice cnt as a[cnt] - b[cnt] - borrow, over SLICE+1 bits.
  - The low SLICE bits are written into diff slice cnt.
  - Borrow = 1 iff the slice result is negative.
  - cnt increments.
  - After the edge that processes slice NSLICE-1, go to DONE.
- DONE:
  - result_valid=1 and start_ready=0.
  - diff, bout, zero, neg and ovf are stable and held until the edge where result_ready=1; then go to IDLE with result_valid=0.
  - diff is not cleared on exit; its value is don't-care while result_valid=0.
- Latency: acceptance at edge E. result_valid rises after edge E+NSLICE (4 cycles at default). Throughput is at most one operation per NSLICE+2 cycles. Operations never overlap.
- Flags are registered on entry to DONE:
  - bout = final borrow flop.
  - zero = (diff == 0).
  - neg = diff[WIDTH-1].
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
- Boundary cases:
  - Borrow must propagate across every slice boundary. Example: 0 - 1 borrows through all NSLICE slices.
  - bin=1 with a == b gives all-ones diff and bout=1.
  - start_valid asserted while in RUN or DONE is ignored; no capture, no state change.
  - result_ready held high in IDLE or RUN has no effect.
  - result_ready=1 on the very first DONE cycle: the result is consumed in that single cycle.
- Reset mid-operation (in RUN or DONE): abort immediately. All outputs return to reset values and the partial result is discarded.

Test Plan:
- a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, zero=0, neg=0, ovf=0; result_valid high exactly 4 cycles after acceptance.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, neg=1, ovf=0, zero=0. This checks borrow ripple through all 4 slices.
- a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, ovf=1, neg=0, bout=0. Also a=0x12345678, b=0x12345677, bin=1 -> diff=0, zero=1, bout=0.
- Back-pressure on a=0x000000FF, b=0x00000100: hold result_ready=0 for 3 DONE cycles and pulse start_valid with new operands during RUN/DONE. Required: diff=0xFFFFFFFF and bout=1 remain stable, start_ready stays 0, and the new operands are not captured. Then result_ready=1 -> IDLE and start_ready=1 next cycle.
- Drive rst_n=0 asynchronously after 2 RUN cycles -> all outputs 0 immediately. After release: start_ready=1, and a fresh operation 0x10 - 0x01 yields diff=0x0000000F.
